// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: pulses the rPLL reset, qualifies its LOCK and releases staggered downstream resets.
// Define PLL_DYN_ODIV_EN to add runtime output-divider reconfiguration (cfg_* / pll_odsel ports).
module pll_lock_supervisor #(
  parameter int NUM_RST          = 2,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65535,
  parameter int STABLE_CYC       = 1024,
  parameter int GLITCH_CYC       = 4,
  parameter int STAGGER_CYC      = 8,
  parameter int CNT_W            = 8
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic [NUM_RST-1:0] rst_out_n,
  output logic               locked,
  output logic [CNT_W-1:0]   retry_cnt,
  output logic [CNT_W-1:0]   loss_cnt,
`ifdef PLL_DYN_ODIV_EN
  input  logic [5:0]         cfg_odsel,
  input  logic               cfg_req,
  output logic               cfg_ack,
  output logic [5:0]         pll_odsel,
`endif
  output logic [2:0]         state_o
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMR_MAX = max_of(max_of(max_of(RST_PULSE_CYC, LOCK_TIMEOUT_CYC),
                                         max_of(STABLE_CYC, STAGGER_CYC)), GLITCH_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_RST + 1);

  localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(RST_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] STAGGER_LAST = TMR_W'(STAGGER_CYC - 1);
  localparam logic [TMR_W-1:0] GLITCH_LAST  = TMR_W'(GLITCH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;

  typedef enum logic [2:0] {
    S_PULSE     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  state_e             r_state;
  logic               r_lock_meta;
  logic               r_lock_s;
  logic [TMR_W-1:0]   r_tmr;
  logic [IDX_W-1:0]   r_idx;
  logic               r_pll_reset;
  logic [NUM_RST-1:0] r_rst_n;
  logic               r_locked;
  logic [CNT_W-1:0]   r_retry_cnt;
  logic [CNT_W-1:0]   r_loss_cnt;
`ifdef PLL_DYN_ODIV_EN
  logic [5:0]         r_odsel;
  logic               r_cfg_pend;
  logic               r_cfg_ack;
`endif

  // One shared timer serves as pulse length, lock timeout, stable count, stagger and glitch count.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PULSE;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_tmr       <= '0;
      r_idx       <= '0;
      r_pll_reset <= 1'b1;
      r_rst_n     <= '0;
      r_locked    <= 1'b0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
`ifdef PLL_DYN_ODIV_EN
      r_odsel     <= '0;
      r_cfg_pend  <= 1'b0;
      r_cfg_ack   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking keeps the two synchroniser stages distinct flops; blocking would collapse them.
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
`ifdef PLL_DYN_ODIV_EN
      r_cfg_ack   <= 1'b0;
`endif
      case (r_state)
        S_PULSE: begin
          if (r_tmr == PULSE_LAST) begin
            r_state     <= S_WAIT_LOCK;
            r_tmr       <= '0;
            r_pll_reset <= 1'b0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= S_STABLE;
            r_tmr   <= '0;
          end else if (r_tmr == TIMEOUT_LAST) begin
            r_state     <= S_PULSE;
            r_tmr       <= '0;
            r_pll_reset <= 1'b1;
            r_retry_cnt <= (r_retry_cnt == CNT_SAT) ? r_retry_cnt : r_retry_cnt + 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_tmr   <= '0;
          end else if (r_tmr == STABLE_LAST) begin
            r_state <= S_RELEASE;
            r_tmr   <= '0;
            r_rst_n <= NUM_RST'(1);
            r_idx   <= IDX_W'(1);
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!r_lock_s) begin
            r_state     <= S_PULSE;
            r_tmr       <= '0;
            r_pll_reset <= 1'b1;
            r_rst_n     <= '0;
            r_loss_cnt  <= (r_loss_cnt == CNT_SAT) ? r_loss_cnt : r_loss_cnt + 1'b1;
          end else if (r_idx == IDX_W'(NUM_RST)) begin
            // Last bit went high on the previous edge; locked follows one cycle later.
            r_state  <= S_RUN;
            r_tmr    <= '0;
            r_locked <= 1'b1;
`ifdef PLL_DYN_ODIV_EN
            r_cfg_ack  <= r_cfg_pend;
            r_cfg_pend <= 1'b0;
`endif
          end else if (r_tmr == STAGGER_LAST) begin
            r_rst_n <= r_rst_n | (NUM_RST'(1) << r_idx);
            r_idx   <= r_idx + 1'b1;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_RUN: begin
          if (!r_lock_s && (r_tmr == GLITCH_LAST)) begin
            r_state     <= S_PULSE;
            r_tmr       <= '0;
            r_pll_reset <= 1'b1;
            r_rst_n     <= '0;
            r_locked    <= 1'b0;
            r_loss_cnt  <= (r_loss_cnt == CNT_SAT) ? r_loss_cnt : r_loss_cnt + 1'b1;
`ifdef PLL_DYN_ODIV_EN
          end else if (cfg_req) begin
            r_odsel     <= cfg_odsel;
            r_cfg_pend  <= 1'b1;
            r_state     <= S_PULSE;
            r_tmr       <= '0;
            r_pll_reset <= 1'b1;
            r_rst_n     <= '0;
            r_locked    <= 1'b0;
`endif
          end else if (!r_lock_s) begin
            r_tmr <= r_tmr + 1'b1;
          end else begin
            r_tmr <= '0;
          end
        end
        default: begin
          r_state     <= S_PULSE;
          r_tmr       <= '0;
          r_pll_reset <= 1'b1;
          r_rst_n     <= '0;
          r_locked    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset = r_pll_reset;
  assign rst_out_n = r_rst_n;
  assign locked    = r_locked;
  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;
  assign state_o   = r_state;
`ifdef PLL_DYN_ODIV_EN
  assign cfg_ack   = r_cfg_ack;
  assign pll_odsel = r_odsel;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed, cycle-counted checks of lock qualification, staggered release and re-arm.
// Edge numbers below count clkin rising edges after the latest reset release.
module tb_pll_lock_supervisor;

  logic       clkin;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic [1:0] rst_out_n;
  logic       locked;
  logic [1:0] retry_cnt;
  logic [1:0] loss_cnt;
  logic [2:0] state_o;
`ifdef PLL_DYN_ODIV_EN
  logic [5:0] cfg_odsel;
  logic       cfg_req;
  logic       cfg_ack;
  logic [5:0] pll_odsel;
`endif

  int n_tests;
  int n_fail;
  int cyc;

  pll_lock_supervisor #(
    .NUM_RST         (2),
    .RST_PULSE_CYC   (16),
    .LOCK_TIMEOUT_CYC(100),
    .STABLE_CYC      (1024),
    .GLITCH_CYC      (4),
    .STAGGER_CYC     (8),
    .CNT_W           (2)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .rst_out_n(rst_out_n),
    .locked   (locked),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
`ifdef PLL_DYN_ODIV_EN
    .cfg_odsel(cfg_odsel),
    .cfg_req  (cfg_req),
    .cfg_ack  (cfg_ack),
    .pll_odsel(pll_odsel),
`endif
    .state_o  (state_o)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clkin);
      cyc++;
    end
    #1;
  endtask

  task automatic goto(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic release_reset;
    @(posedge clkin);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b1;
    pll_lock = 1'b0;
`ifdef PLL_DYN_ODIV_EN
    cfg_odsel = '0;
    cfg_req   = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #10;
    check("rst_pll_reset", pll_reset, 1);
    check("rst_rst_out_n", rst_out_n, 0);
    check("rst_locked",    locked,    0);
    check("rst_retry",     retry_cnt, 0);
    check("rst_loss",      loss_cnt,  0);
    check("rst_state",     state_o,   0);

    // Lock at edge 40 -> STABLE at 43, bit0 at 43+1024, bit1 8 later, locked 1 later.
    release_reset();
    goto(15);   check("pulse_hi_15",   pll_reset, 1);
                check("pulse_state",   state_o,   0);
    goto(16);   check("pulse_lo_16",   pll_reset, 0);
                check("wait_state",    state_o,   1);
    goto(40);   pll_lock = 1'b1;
    goto(42);   check("sync_lag",      state_o,   1);
    goto(43);   check("stable_entry",  state_o,   2);
    goto(1066); check("pre_rel0",      rst_out_n, 2'b00);
    goto(1067); check("rel0",          rst_out_n, 2'b01);
                check("release_state", state_o,   3);
    goto(1074); check("pre_rel1",      rst_out_n, 2'b01);
    goto(1075); check("rel1",          rst_out_n, 2'b11);
                check("pre_locked",    locked,    0);
    goto(1076); check("locked",        locked,    1);
                check("run_state",     state_o,   4);

    // Three-cycle dip in RUN is ignored.
    goto(1080); pll_lock = 1'b0;
    step(3);    pll_lock = 1'b1;
    goto(1090); check("dip3_rst",      rst_out_n, 2'b11);
                check("dip3_locked",   locked,    1);
                check("dip3_state",    state_o,   4);
                check("dip3_loss",     loss_cnt,  0);

    // Four-cycle dip: lock_s low seen at edges 1093..1096, loss on the fourth.
    pll_lock = 1'b0;
    step(4);    pll_lock = 1'b1;
    goto(1095); check("dip4_pre",      state_o,   4);
    goto(1096); check("dip4_state",    state_o,   0);
                check("dip4_rst",      rst_out_n, 2'b00);
                check("dip4_locked",   locked,    0);
                check("dip4_loss",     loss_cnt,  1);
                check("dip4_pll_rst",  pll_reset, 1);

    // Relock: WAIT at 1112, STABLE at 1113; one-cycle drop seen at count 500.
    goto(1112); check("relock_wait",   state_o,   1);
    goto(1113); check("relock_stable", state_o,   2);
    goto(1611); pll_lock = 1'b0;
    step(1);    pll_lock = 1'b1;
    goto(1613); check("stab_hold",     state_o,   2);
    goto(1614); check("stab_drop",     state_o,   1);
                check("stab_retry",    retry_cnt, 0);
    goto(1615); check("stab_reenter",  state_o,   2);
    goto(2638); check("stab_pre_rel",  rst_out_n, 2'b00);
    goto(2639); check("stab_rel0",     rst_out_n, 2'b01);

    // Async reset mid-RELEASE takes effect before the next edge.
    goto(2641);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pll_reset", pll_reset, 1);
    check("arst_rst",       rst_out_n, 0);
    check("arst_locked",    locked,    0);
    check("arst_state",     state_o,   0);
    check("arst_loss",      loss_cnt,  0);

    // Full sequence again with lock already high; then lose lock during RELEASE.
    release_reset();
    goto(15);   check("re_pulse_hi",   pll_reset, 1);
    goto(16);   check("re_pulse_lo",   pll_reset, 0);
    goto(17);   check("re_stable",     state_o,   2);
    goto(1040); check("re_pre_rel0",   rst_out_n, 2'b00);
    goto(1041); check("re_rel0",       rst_out_n, 2'b01);
    goto(1042); pll_lock = 1'b0;
    step(1);    pll_lock = 1'b1;
    goto(1044); check("relloss_pre",   state_o,   3);
    goto(1045); check("relloss_state", state_o,   0);
                check("relloss_rst",   rst_out_n, 2'b00);
                check("relloss_loss",  loss_cnt,  1);
                check("relloss_pllr",  pll_reset, 1);

`ifdef PLL_DYN_ODIV_EN
    #2 rst_n = 1'b0;
    release_reset();
    goto(16);   cfg_odsel = 6'h08; cfg_req = 1'b1;
    step(1);    cfg_req = 1'b0; cfg_odsel = 6'h00;
    check("cfg_wait_odsel", pll_odsel, 0);
    goto(1050); check("cfg_run1",      state_o,   4);
                check("cfg_no_ack",    cfg_ack,   0);
    goto(1052); cfg_odsel = 6'h08; cfg_req = 1'b1;
    step(1);    cfg_req = 1'b0;
    check("cfg_odsel",      pll_odsel, 6'h08);
    check("cfg_state",      state_o,   0);
    check("cfg_rst",        rst_out_n, 2'b00);
    check("cfg_locked",     locked,    0);
    goto(2102); check("cfg_ack_pre",   cfg_ack,   0);
    goto(2103); check("cfg_run2",      state_o,   4);
                check("cfg_ack",       cfg_ack,   1);
    goto(2104); check("cfg_ack_end",   cfg_ack,   0);
                check("cfg_loss",      loss_cnt,  0);
`endif

    // No lock: timeout every 100 WAIT cycles, retry_cnt saturates at 3.
    #2 rst_n = 1'b0;
    pll_lock = 1'b0;
    release_reset();
    goto(115);  check("to_wait",       state_o,   1);
                check("to_retry0",     retry_cnt, 0);
    goto(116);  check("to_pulse",      state_o,   0);
                check("to_retry1",     retry_cnt, 1);
                check("to_pll_reset",  pll_reset, 1);
    goto(232);  check("to_retry2",     retry_cnt, 2);
    goto(348);  check("to_retry3",     retry_cnt, 3);
    goto(463);  check("to_wait4",      state_o,   1);
    goto(464);  check("to_sat",        retry_cnt, 3);
                check("to_pulse4",     state_o,   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises one Gowin rPLL instance from its reference clock domain. Drives the PLL reset and filters and qualifies the asynchronous LOCK output. Releases NUM_RST downstream reset outputs in staggered order once lock is stable, and re-arms automatically on lock loss or lock timeout. Sits beside each PLL wrapper in the clocking top level and generalises the fixed, reset-less PLL instantiation into a self-recovering, multi-domain reset source.

Parameters:
NUM_RST, 2, number of downstream active-low reset outputs (1..8)
RST_PULSE_CYC, 16, PLL reset pulse length in clkin cycles (>=2)
LOCK_TIMEOUT_CYC, 65535, cycles allowed in WAIT_LOCK before retry
STABLE_CYC, 1024, cycles lock must stay high before release
GLITCH_CYC, 4, lock-low cycles tolerated in RUN before declaring loss
STAGGER_CYC, 8, cycles between successive reset releases
CNT_W, 8, width of retry and loss counters

Ports:
clkin  in  1  PLL reference clock; the only clock
rst_n  in  1  asynchronous active-low reset
pll_lock  in  1  raw rPLL LOCK, asynchronous to clkin
pll_reset  out  1  to rPLL RESET, active high
rst_out_n  out  NUM_RST  downstream resets, active low; bit 0 released first
locked  out  1  high only in RUN
retry_cnt  out  CNT_W  lock-timeout retries, saturating
loss_cnt  out  CNT_W  lock-loss events in RUN, saturating
state_o  out  3  current FSM state encoding, for debug

Behaviour:
- Clocking and reset: one clock, clkin. Reset rst_n is asynchronous and active-low.
- Reset values: pll_reset=1, rst_out_n=all 0, locked=0, counters=0, state=PULSE.
- pll_lock passes through a 2-FF synchroniser. All references to lock below mean lock_s, which lags pll_lock by 2 cycles.
- States: PULSE=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- PULSE: pll_reset=1 for exactly RST_PULSE_CYC cycles, then go to WAIT_LOCK with pll_reset=0.
- WAIT_LOCK: a timer counts from 0.
  - lock_s=1 -> STABLE.
  - Timer reaches LOCK_TIMEOUT_CYC-1 without lock -> retry_cnt+1 (saturating), go to PULSE.
- STABLE: counts consecutive lock_s=1 cycles.
  - Any lock_s=0 -> back to WAIT_LOCK. The timer restarts and retry_cnt is unchanged.
  - Count reaches STABLE_CYC -> RELEASE.
- RELEASE: rst_out_n[i] goes high STAGGER_CYC*i cycles after RELEASE entry; bit 0 goes high on the first RELEASE cycle.
  - After bit NUM_RST-1 is released -> RUN. locked=1 from the next cycle.
  - lock_s=0 during RELEASE -> all rst_out_n=0 same cycle, loss_cnt+1, go to PULSE.
- RUN: a glitch counter counts consecutive lock_s=0 cycles and clears on lock_s=1.
  - Counter reaching GLITCH_CYC -> on that edge: all rst_out_n=0 and locked=0, loss_cnt+1, go to PULSE.
  - Shorter dips are ignored: no output change.
- Reset mid-operation: rst_n low forces reset values immediately (asynchronous), including rst_out_n low. Release restarts at PULSE.
- rst_out_n deassertion is synchronous to clkin. Assertion is immediate on loss, async reset, or the PULSE entry edge.
- Counter width: timers are sized $clog2(max parameter + 1). Counters stick at 2^CNT_W-1.

Optional Feature:
PLL_DYN_ODIV_EN
- Defined: adds ports cfg_odsel in 6, cfg_req in 1, cfg_ack out 1, pll_odsel out 6. pll_odsel resets to 0. A cfg_req pulse accepted in RUN does the following in the same cycle:
  - registers cfg_odsel into pll_odsel;
  - asserts all rst_out_n low;
  - goes to PULSE without incrementing loss_cnt.
- cfg_ack pulses for 1 cycle on the next entry to RUN.
- cfg_req outside RUN is ignored and no ack follows.
- Undefined: none of these ports or registers exist, and the divider is fixed in the PLL wrapper.

Test Plan:
- Lock rises 40 cycles after reset release, defaults -> pll_reset high for exactly 16 cycles. rst_out_n[0] rises STABLE_CYC+3 cycles after pll_lock rises (2 sync + 1 STABLE-entry cycle, then STABLE_CYC counting); rst_out_n[1] rises 8 cycles later, and locked rises 1 cycle after that.
- pll_lock never asserts, LOCK_TIMEOUT_CYC=100 -> second PULSE starts 100 cycles after first WAIT_LOCK entry. retry_cnt=1, then 2 after the next timeout. Saturation checked with CNT_W=2: stays at 3.
- In RUN, pll_lock low for 3 cycles -> no output change. Low for 4 cycles -> rst_out_n=0, locked=0, loss_cnt=1, state=PULSE.
- Lock drops for 1 cycle at STABLE count 500 -> back to WAIT_LOCK. Release timing restarts from the next lock rise, and retry_cnt is unchanged.
- rst_n asserted during RELEASE with bit 0 released -> all outputs at reset values within the same cycle. On deassert the full sequence repeats from PULSE.
- PLL_DYN_ODIV_EN: cfg_req with cfg_odsel=6'h08 in RUN -> pll_odsel=8 the next cycle, full relock, and one cfg_ack pulse on RUN re-entry. loss_cnt is unchanged. A cfg_req in WAIT_LOCK produces no ack.
